// File: rtl/axis_dsm_decimator_if.sv
// AXI-Stream style handshake bundle used for the decimator's bit input and sample output.
interface axis_dsm_decimator_if #(
  parameter int W = 1
) ();
  logic [W-1:0] tdata;
  logic         tvalid;
  logic         tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/axis_dsm_decimator.sv
// CIC decimator turning a 1-bit delta-sigma stream into WIDTH-bit PCM samples.
// Optional macro AXIS_DSM_DECIMATOR_SIGNED_EN selects two's complement output.
module axis_dsm_decimator #(
  parameter int WIDTH      = 16,
  parameter int ORDER      = 2,
  parameter int DECIMATION = 16
) (
  input  logic                  aclk,
  input  logic                  arst_n,
  axis_dsm_decimator_if.slave   s_axis_data,
  axis_dsm_decimator_if.master  m_axis_data
);
  localparam int LOG2D = $clog2(DECIMATION);
  localparam int G     = ORDER * LOG2D + 1;
  localparam int SH    = WIDTH - ORDER * LOG2D;

  logic [LOG2D-1:0] phase_p0;
  logic [G-1:0]     integ_p0  [ORDER];
  logic [G-1:0]     integ_nxt [ORDER];
  logic [G-1:0]     dly_p1    [ORDER];
  logic [G-1:0]     comb      [ORDER+1];
  logic [WIDTH-1:0] data_p2;
  logic             vld_p2;
  logic             last_phase;
  logic             beat;
  logic             dec_beat;

  // Full-scale input gives exactly 2^WIDTH after the shift, hence the clamp.
  function automatic logic [WIDTH-1:0] sat_scale(input logic [G-1:0] y);
    logic [WIDTH:0] s;
    s = (WIDTH+1)'(y) << SH;
    return s[WIDTH] ? {WIDTH{1'b1}} : s[WIDTH-1:0];
  endfunction

  function automatic logic [WIDTH-1:0] fmt_out(input logic [WIDTH-1:0] v);
`ifdef AXIS_DSM_DECIMATOR_SIGNED_EN
    return {~v[WIDTH-1], v[WIDTH-2:0]};
`else
    return v;
`endif
  endfunction

  assign last_phase         = (phase_p0 == LOG2D'(DECIMATION - 1));
  assign s_axis_data.tready = arst_n && (!last_phase || !vld_p2 || m_axis_data.tready);
  assign beat               = s_axis_data.tvalid && s_axis_data.tready;
  assign dec_beat           = beat && last_phase;
  assign m_axis_data.tdata  = data_p2;
  assign m_axis_data.tvalid = vld_p2;

  // p0: integrators at the bit rate, each fed by the registered previous stage
  always_comb begin
    integ_nxt[0] = integ_p0[0] + G'(s_axis_data.tdata);
    for (int k = 1; k < ORDER; k++) begin
      integ_nxt[k] = integ_p0[k] + integ_p0[k-1];
    end
  end

  // p1: combs at the decimated rate, driven by the next-state last integrator
  always_comb begin
    comb[0] = integ_nxt[ORDER-1];
    for (int k = 0; k < ORDER; k++) begin
      comb[k+1] = comb[k] - dly_p1[k];
    end
  end

  always_ff @(posedge aclk) begin
    if (!arst_n) begin
      phase_p0 <= '0;
      for (int k = 0; k < ORDER; k++) begin
        integ_p0[k] <= '0;
        dly_p1[k]   <= '0;
      end
      data_p2 <= '0;
      vld_p2  <= 1'b0;
    end else begin
      if (beat) begin
        phase_p0 <= phase_p0 + 1'b1;
        for (int k = 0; k < ORDER; k++) begin
          integ_p0[k] <= integ_nxt[k];
        end
      end
      // p2: output register; a reload on the accept cycle keeps valid high
      if (dec_beat) begin
        for (int k = 0; k < ORDER; k++) begin
          dly_p1[k] <= comb[k];
        end
        data_p2 <= fmt_out(sat_scale(comb[ORDER]));
        vld_p2  <= 1'b1;
      end else if (m_axis_data.tready) begin
        vld_p2 <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_axis_dsm_decimator.sv
// Randomized bench for axis_dsm_decimator against an FIR-equivalent CIC reference model.
module tb_axis_dsm_decimator;
  localparam int WIDTH      = 16;
  localparam int ORDER      = 2;
  localparam int DECIMATION = 16;
  localparam int LOG2D      = $clog2(DECIMATION);
  localparam int SH         = WIDTH - ORDER * LOG2D;
  localparam int NT         = ORDER * (DECIMATION - 1) + 1;

  logic aclk   = 1'b0;
  logic arst_n = 1'b0;
  always #5 aclk = ~aclk;

  axis_dsm_decimator_if #(.W(1))     s_if ();
  axis_dsm_decimator_if #(.W(WIDTH)) m_if ();

  axis_dsm_decimator #(
    .WIDTH(WIDTH), .ORDER(ORDER), .DECIMATION(DECIMATION)
  ) dut (
    .aclk       (aclk),
    .arst_n     (arst_n),
    .s_axis_data(s_if),
    .m_axis_data(m_if)
  );

  int               n_tests = 0;
  int               n_fail  = 0;
  longint           h [NT];
  bit               hist [$];
  bit               held;
  int               held_idx;
  logic [WIDTH-1:0] exp_tdata;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Clamp to WIDTH bits, then apply the configured output format.
  function automatic logic [WIDTH-1:0] ref_format(input longint raw);
    longint           r;
    logic [WIDTH-1:0] v;
    r = raw;
    if (r >= (longint'(1) << WIDTH)) r = (longint'(1) << WIDTH) - 1;
    v = r[WIDTH-1:0];
`ifdef AXIS_DSM_DECIMATOR_SIGNED_EN
    v[WIDTH-1] = ~v[WIDTH-1];
`endif
    return v;
  endfunction

  // The CIC is a boxcar^ORDER FIR; each registered integrator stage after the first adds one bit of delay.
  function automatic logic [WIDTH-1:0] ref_sample();
    longint acc;
    int     n;
    int     idx;
    acc = 0;
    n   = hist.size() - 1;
    for (int j = 0; j < NT; j++) begin
      idx = n - (ORDER - 1) - j;
      if (idx >= 0 && hist[idx]) acc += h[j];
    end
    return ref_format(acc << SH);
  endfunction

  function automatic logic [WIDTH-1:0] settled_const(input int mode);
`ifdef AXIS_DSM_DECIMATOR_SIGNED_EN
    case (mode)
      0:       return 16'h8000;
      1:       return 16'h7FFF;
      default: return 16'h0000;
    endcase
`else
    case (mode)
      0:       return 16'h0000;
      1:       return 16'hFFFF;
      default: return 16'h8000;
    endcase
`endif
  endfunction

  function automatic logic pick_bit(input int mode);
    case (mode)
      0:       return 1'b0;
      1:       return 1'b1;
      2:       return (hist.size() % 2) == 0;
      default: return 1'($urandom_range(1));
    endcase
  endfunction

  // mode: 0 zeros, 1 ones, 2 alternating 1,0, 3 random bits
  task automatic step(input logic rst_v, input int mode, input int vpct, input int rpct);
    logic exp_rdy;
    logic accept;
    @(posedge aclk);
    #1;
    arst_n      = rst_v;
    s_if.tvalid = ($urandom_range(99) < vpct);
    s_if.tdata  = pick_bit(mode);
    m_if.tready = ($urandom_range(99) < rpct);
    @(negedge aclk);
    exp_rdy = arst_n && (((hist.size() % DECIMATION) != DECIMATION - 1) || !held || m_if.tready);
    check("s_tready", 32'(s_if.tready), 32'(exp_rdy));
    check("m_tvalid", 32'(m_if.tvalid), 32'(held));
    check("m_tdata",  32'(m_if.tdata),  32'(exp_tdata));
    if (!arst_n) begin
      hist.delete();
      held      = 1'b0;
      exp_tdata = '0;
    end else begin
      accept = held && m_if.tready;
      if (accept && mode <= 2 && held_idx >= ORDER)
        check("settled", 32'(m_if.tdata), 32'(settled_const(mode)));
      if (s_if.tvalid && exp_rdy) hist.push_back(s_if.tdata);
      if (s_if.tvalid && exp_rdy && (hist.size() % DECIMATION) == 0) begin
        exp_tdata = ref_sample();
        held      = 1'b1;
        held_idx  = hist.size() / DECIMATION - 1;
      end else if (accept) begin
        held = 1'b0;
      end
    end
  endtask

  task automatic run(input int cycles, input int mode, input int vpct, input int rpct);
    for (int i = 0; i < cycles; i++) step(1'b1, mode, vpct, rpct);
  endtask

  task automatic do_reset(input int mode);
    step(1'b0, mode, 100, 100);
    step(1'b0, mode, 100, 100);
  endtask

  initial begin
    longint tmp [NT];
    int     guard;
    h[0] = 1;
    for (int i = 1; i < NT; i++) h[i] = 0;
    for (int o = 0; o < ORDER; o++) begin
      for (int i = 0; i < NT; i++) begin
        tmp[i] = 0;
        for (int t = 0; t < DECIMATION; t++)
          if (i - t >= 0) tmp[i] += h[i-t];
      end
      for (int i = 0; i < NT; i++) h[i] = tmp[i];
    end
    held        = 1'b0;
    held_idx    = 0;
    exp_tdata   = '0;
    s_if.tvalid = 1'b0;
    s_if.tdata  = 1'b0;
    m_if.tready = 1'b1;

    do_reset(0); run(160, 0, 100, 100);
    do_reset(1); run(160, 1, 100, 100);
    do_reset(2); run(160, 2, 100, 100);
    do_reset(3); run(1500, 3, 75, 70);

    // Long stall with continuous input, then release.
    do_reset(2);
    run(40, 2, 100, 100);
    run(100, 2, 100, 0);
    run(120, 2, 100, 100);

    // Reset in the middle of a frame.
    do_reset(3);
    guard = 0;
    while (!(hist.size() > DECIMATION && (hist.size() % DECIMATION) == 7) && guard < 2000) begin
      step(1'b1, 3, 80, 80);
      guard++;
    end
    check("mid_frame_reached", 32'(guard < 2000), 32'd1);
    step(1'b0, 3, 100, 100);
    run(200, 3, 90, 80);

    // Reset while an unaccepted sample is held.
    guard = 0;
    while (!held && guard < 500) begin
      step(1'b1, 3, 100, 0);
      guard++;
    end
    check("held_reached", 32'(guard < 500), 32'd1);
    run(5, 3, 100, 0);
    step(1'b0, 3, 100, 0);
    run(200, 3, 100, 100);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
